ceyloniac_alu_sequencer: RTL and testbench
==========================================

# ceyloniac_alu_sequencer

Issue-side controller for the combinational Ceyloniac ALU. It accepts operation requests over a valid/ready channel and drives the ALU operand and select lines from registers. It captures the ALU result and returns it over a valid/ready response channel. It also executes the bit-field extract opcode (4'b1110) itself, iteratively, because the ALU does not implement it. It sits between the core's execute-stage issue logic and the ALU instance.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the ALU's data width
- OP_WIDTH, 4, opcode width; must match the ALU's select width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  OP_WIDTH  ALU opcode
- req_a, req_b  in  DATA_WIDTH  operands
- alu_in_a, alu_in_b  out  DATA_WIDTH  registered operands to ALU
- alu_sel  out  OP_WIDTH  registered opcode to ALU
- alu_out  in  DATA_WIDTH  ALU combinational result
- alu_status  in  1  ALU status bit
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_WIDTH  result
- rsp_status  out  1  captured status
- done_count  out  16  completed-response counter; wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, ISSUE, EXTRACT, RESP.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready.
- **IDLE, accept with op != 4'b1110:** latch req_a, req_b and req_op into alu_in_a, alu_in_b and alu_sel. Go to ISSUE.
- **ISSUE:** capture alu_out into rsp_data and alu_status into rsp_status. Go to RESP.
- **IDLE, accept with op == 4'b1110:** pos = req_b[10:6] and len = req_b[15:11].
  - Clear rsp_data and the bit counter i. Go to EXTRACT.
  - alu_* outputs keep their previous values.
- **EXTRACT:**
  - If i == len, go to RESP.
  - Otherwise set rsp_data[i] = a[pos+i], or 0 when pos+i >= DATA_WIDTH. Then i++.
  - rsp_status = 0 for extract.
- **RESP:** rsp_valid = 1. rsp_data and rsp_status are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: done_count++ and go to IDLE.
- Unused opcodes pass through to the ALU unchanged. The sequencer does no opcode decode except 4'b1110.
- Arithmetic width: all ops produce DATA_WIDTH-bit results. Truncation is the ALU's.

## Timing
- Reset values: state IDLE, req_ready 1 (as a function of state), rsp_valid 0, rsp_data 0, rsp_status 0, alu_in_a 0, alu_in_b 0, alu_sel 0, done_count 0, i 0.
- ALU op accepted at cycle T: ISSUE at T+1, rsp_valid first high at T+2.
- Extract accepted at T: rsp_valid first high at T+2+len. len=0 gives rsp_data 0 at T+2.
- Response accepted at cycle R: IDLE at R+1, req_ready high at R+1. No same-cycle bypass. Peak throughput is one ALU op per 3 cycles.
- rsp_ready held low: state stays RESP indefinitely with stable outputs, and req_ready stays 0.
- Reset asserted in any state, including mid-EXTRACT or RESP: all registers take their reset values on that edge. The in-flight operation is dropped and done_count is not incremented.
- req_valid while not IDLE: ignored. The requester must hold the request until req_ready.

## Structure
- Shared package ceyloniac_alu_pkg holds:
  - opcode localparams (OP_ADD 4'b0000 … OP_EXTRACT 4'b1110, OP_PASS 4'b1111)
  - FSM state encoding
  - extract field bounds (POS_LSB 6, POS_MSB 10, LEN_LSB 11, LEN_MSB 15)
- One natural sub-module: ceyloniac_bitfield_extract.
  - Contains the iterative bit counter and shift datapath.
  - Interface: start/pos/len/a in, done/result out.
  - Instantiated by the sequencer's EXTRACT state.

## Test plan
- ADD: a=5, b=7, op=0000 accepted at T -> rsp_valid at T+2, rsp_data=12, rsp_status=0, done_count=1.
- Shift-left: a=1, b=4, op=0110 -> rsp_data=0x00000010 at T+2. alu_sel=0110 is observed on the ALU port during ISSUE.
- Extract in range: a=0xDEADBEEF, b=0x00004100 (len 8, pos 4), op=1110 -> rsp_data=0x000000EE, rsp_valid at T+10.
- Extract past MSB and zero-length:
  - a=0xDEADBEEF, b=0x00004700 (len 8, pos 28) -> rsp_data=0x0000000D.
  - b=0x00000100 (len 0) -> rsp_data=0 at T+2.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data stable, req_ready=0, a second req_valid is not accepted. rsp_ready=1 -> IDLE next cycle.
- Reset mid-extract: assert reset at cycle T+4 of a len-8 extract -> next cycle rsp_valid=0, req_ready=1, done_count unchanged, alu_* = 0.

Source files
------------

// File: rtl/ceyloniac_alu_pkg.sv
// Shared definitions for the Ceyloniac ALU sequencer: opcodes, FSM encoding
// and the bit-field extract operand layout carried in operand B.
package ceyloniac_alu_pkg;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_SHL     = 4'b0110;
  localparam logic [3:0] OP_SHR     = 4'b0111;
  localparam logic [3:0] OP_EXTRACT = 4'b1110;
  localparam logic [3:0] OP_PASS    = 4'b1111;

  // Extract fields inside operand B
  localparam int POS_LSB = 6;
  localparam int POS_MSB = 10;
  localparam int LEN_LSB = 11;
  localparam int LEN_MSB = 15;
  localparam int FIELD_W = POS_MSB - POS_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXTRACT,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/ceyloniac_bitfield_extract.sv
// Iterative bit-field extractor: one result bit per cycle, LSB first.
// Source bits beyond the operand MSB read as zero.
module ceyloniac_bitfield_extract
  import ceyloniac_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [FIELD_W-1:0]    pos_i,
  input  logic [FIELD_W-1:0]    len_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic                  busy_q;
  logic [FIELD_W-1:0]    i_q;
  logic [FIELD_W-1:0]    pos_q;
  logic [FIELD_W-1:0]    len_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [FIELD_W:0]      src_idx;
  logic                  src_bit;

  // Carry bit of the index means pos+i ran past the operand MSB
  assign src_idx  = {1'b0, pos_q} + {1'b0, i_q};
  assign src_bit  = src_idx[FIELD_W] ? 1'b0 : a_q[src_idx[FIELD_W-1:0]];
  assign done_o   = busy_q && (i_q == len_q);
  assign result_o = result_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q   <= 1'b0;
      i_q      <= '0;
      pos_q    <= '0;
      len_q    <= '0;
      a_q      <= '0;
      result_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      i_q      <= '0;
      pos_q    <= pos_i;
      len_q    <= len_i;
      a_q      <= a_i;
      result_q <= '0;
    end else if (busy_q) begin
      if (i_q == len_q) begin
        busy_q <= 1'b0;
      end else begin
        result_q[i_q] <= src_bit;
        i_q           <= i_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ceyloniac_alu_sequencer.sv
// Issue-side controller for the combinational Ceyloniac ALU; runs the
// bit-field extract opcode locally since the ALU lacks it.
module ceyloniac_alu_sequencer
  import ceyloniac_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [OP_WIDTH-1:0]   req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  output logic [DATA_WIDTH-1:0] alu_in_a_o,
  output logic [DATA_WIDTH-1:0] alu_in_b_o,
  output logic [OP_WIDTH-1:0]   alu_sel_o,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  input  logic                  alu_status_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_status_o,
  output logic [15:0]           done_count_o
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_sel_q, alu_sel_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_status_q, rsp_status_d;
  logic [15:0]           done_cnt_q, done_cnt_d;
  logic                  ext_start;
  logic                  ext_done;
  logic [DATA_WIDTH-1:0] ext_result;

  ceyloniac_bitfield_extract #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (ext_start),
    .pos_i   (req_b_i[POS_MSB:POS_LSB]),
    .len_i   (req_b_i[LEN_MSB:LEN_LSB]),
    .a_i     (req_a_i),
    .done_o  (ext_done),
    .result_o(ext_result)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    done_cnt_d   = done_cnt_q;
    ext_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_op_i == OP_EXTRACT) begin
            ext_start    = 1'b1;
            rsp_data_d   = '0;
            rsp_status_d = 1'b0;
            state_d      = ST_EXTRACT;
          end else begin
            alu_a_d   = req_a_i;
            alu_b_d   = req_b_i;
            alu_sel_d = req_op_i;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        rsp_data_d   = alu_out_i;
        rsp_status_d = alu_status_i;
        state_d      = ST_RESP;
      end
      ST_EXTRACT: begin
        if (ext_done) begin
          rsp_data_d = ext_result;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
  end

  assign alu_in_a_o   = alu_a_q;
  assign alu_in_b_o   = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;
  assign done_count_o = done_cnt_q;

endmodule

// File: tb/tb_ceyloniac_alu_sequencer.sv
// Randomized bench for ceyloniac_alu_sequencer against a transaction-level
// model; includes a stand-in combinational ALU.
module tb_ceyloniac_alu_sequencer;
  import ceyloniac_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic [31:0] alu_in_a_o, alu_in_b_o;
  logic [3:0]  alu_sel_o;
  logic [31:0] alu_out_i;
  logic        alu_status_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_status_o;
  logic [15:0] done_count_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_done;
  logic [31:0] exp_alu_a, exp_alu_b;
  logic [3:0]  exp_alu_sel;

  always #5 clk = ~clk;

  ceyloniac_alu_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .alu_in_a_o  (alu_in_a_o),
    .alu_in_b_o  (alu_in_b_o),
    .alu_sel_o   (alu_sel_o),
    .alu_out_i   (alu_out_i),
    .alu_status_i(alu_status_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_status_o(rsp_status_o),
    .done_count_o(done_count_o)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      OP_PASS: return a;
      default: return a + b + 32'(op);
    endcase
  endfunction

  // Stand-in ALU: status is the parity of the result
  always_comb begin
    alu_out_i    = alu_fn(alu_sel_o, alu_in_a_o, alu_in_b_o);
    alu_status_i = ^alu_out_i;
  end

  function automatic logic [31:0] extract_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    logic [63:0] mask;
    int pos, len;
    pos  = int'(b[10:6]);
    len  = int'(b[15:11]);
    wide = {32'b0, a} >> pos;
    mask = (64'd1 << len) - 64'd1;
    return wide[31:0] & mask[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_alu_regs(input string tag);
    check({tag, "_alu_a"}, alu_in_a_o, exp_alu_a);
    check({tag, "_alu_b"}, alu_in_b_o, exp_alu_b);
    check({tag, "_alu_sel"}, 32'(alu_sel_o), 32'(exp_alu_sel));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] exp_data;
    logic        exp_status;
    int          lat;
    int          n;
    if (op == OP_EXTRACT) begin
      exp_data   = extract_ref(a, b);
      exp_status = 1'b0;
      lat        = int'(b[15:11]);
    end else begin
      exp_data    = alu_fn(op, a, b);
      exp_status  = ^exp_data;
      lat         = 0;
      exp_alu_a   = a;
      exp_alu_b   = b;
      exp_alu_sel = op;
    end
    check("idle_req_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    @(negedge clk);
    n = 1;
    // Keep a junk request pending while busy; it must be ignored.
    req_op_i = 4'($urandom);
    req_a_i  = $urandom;
    req_b_i  = $urandom;
    if (op != OP_EXTRACT) check_alu_regs("issue");
    while (!rsp_valid_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 32'(n), 32'(2 + lat));
    for (int k = 0; k <= hold; k++) begin
      check("rsp_valid_held", 32'(rsp_valid_o), 32'd1);
      check("rsp_data", rsp_data_o, exp_data);
      check("rsp_status", 32'(rsp_status_o), 32'(exp_status));
      check("busy_req_ready", 32'(req_ready_o), 32'd0);
      if (k == hold) begin
        check_alu_regs("resp");
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    rsp_ready_i = 1'b0;
    exp_done++;
    check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post_req_ready", 32'(req_ready_o), 32'd1);
    check("done_count", 32'(done_count_o), 32'(exp_done));
  endtask

  task automatic reset_mid_extract();
    req_valid_i = 1'b1;
    req_op_i    = OP_EXTRACT;
    req_a_i     = 32'hDEADBEEF;
    req_b_i     = 32'h0000_4100;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_extract_busy", 32'(req_ready_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i     = 1'b0;
    exp_done    = '0;
    exp_alu_a   = '0;
    exp_alu_b   = '0;
    exp_alu_sel = '0;
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_done_count", 32'(done_count_o), 32'(exp_done));
    check("rst_rsp_data", rsp_data_o, 32'd0);
    check_alu_regs("rst");
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset_i     = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    exp_done    = '0;
    exp_alu_a   = '0;
    exp_alu_b   = '0;
    exp_alu_sel = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready_o), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rsp_data", rsp_data_o, 32'd0);
    check("reset_rsp_status", 32'(rsp_status_o), 32'd0);
    check("reset_done_count", 32'(done_count_o), 32'd0);
    check_alu_regs("reset");
    reset_i = 1'b0;
    @(negedge clk);

    run_txn(OP_ADD, 32'd5, 32'd7, 0);
    run_txn(OP_SHL, 32'd1, 32'd4, 1);
    run_txn(OP_EXTRACT, 32'hDEADBEEF, 32'h0000_4100, 0);
    run_txn(OP_EXTRACT, 32'hDEADBEEF, 32'h0000_4700, 2);
    run_txn(OP_EXTRACT, 32'hDEADBEEF, 32'h0000_0100, 0);
    run_txn(OP_XOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 5);
    run_txn(OP_EXTRACT, 32'hFFFF_FFFF, 32'h0000_FFC0, 0);
    reset_mid_extract();
    run_txn(OP_SUB, 32'd3, 32'd10, 0);

    for (int t = 0; t < 40; t++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = OP_EXTRACT;
      a = $urandom;
      b = $urandom;
      run_txn(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
